program_sequencer_v2: RTL

Parametrised next-generation program sequencer for the micro core family. Generates the program-memory address and registered PC. Adds these to the plain jmp/jmp_nz sequencer:
- configurable PC width
- a hardware call/return stack with overflow/underflow flags
- a zero-overhead hardware loop counter

Sits between instruction_decoder (control strobes) and program_memory (address).

---
 rtl/seq_pkg.sv | 21 ++
 rtl/seq_return_stack.sv | 49 ++++
 rtl/program_sequencer_v2.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and helpers for the program sequencer.
// Next-address source encoding, default reset vector, stack-pointer width.
package seq_pkg;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_RET,
    SRC_CALL,
    SRC_JMP,
    SRC_JNZ,
    SRC_LOOP,
    SRC_INC
  } next_src_t;

  localparam int DEFAULT_RESET_VEC = 0;

  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/seq_return_stack.sv
// Parametrised LIFO return-address stack.
// Contents are not reset; only the occupancy counter is.
module seq_return_stack
  import seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [W-1:0]                push_data,
  output logic [W-1:0]                top,
  output logic [sp_width(DEPTH)-1:0]  sp,
  output logic                        full,
  output logic                        empty
);

  localparam int SP_W = sp_width(DEPTH);

  logic [W-1:0] mem [DEPTH];

  assign full  = (sp == SP_W'(DEPTH));
  assign empty = (sp == '0);

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sp == SP_W'(i + 1))
        top = mem[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sp <= '0;
    else if (push && !full)
      sp <= sp + SP_W'(1);
    else if (pop && !empty)
      sp <= sp - SP_W'(1);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (push && !full && sp == SP_W'(i))
        mem[i] <= push_data;
  end

endmodule

// File: rtl/program_sequencer_v2.sv
// Program sequencer: PC, call/return stack, zero-overhead loop.
// Hardware loop is built only when HW_LOOP_EN is defined.
module program_sequencer_v2
  import seq_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4,
  parameter int LOOP_W      = 4,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEFAULT_RESET_VEC)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              hold,
  input  logic                              jmp,
  input  logic                              jmp_nz,
  input  logic                              dont_jmp,
  input  logic [PC_W-1:0]                   jmp_addr,
  input  logic                              call,
  input  logic                              ret,
  input  logic                              loop_set,
  input  logic [LOOP_W-1:0]                 loop_count_in,
  input  logic [PC_W-1:0]                   loop_end_addr,
  output logic [PC_W-1:0]                   pm_addr,
  output logic [PC_W-1:0]                   pc,
  output logic [sp_width(STACK_DEPTH)-1:0]  sp,
  output logic                              stack_overflow,
  output logic                              stack_underflow,
  output logic                              loop_active,
  output logic [LOOP_W-1:0]                 loop_remaining
);

  next_src_t       src;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] nxt;
  logic [PC_W-1:0] top;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            set_of;
  logic            set_uf;
  logic            loop_back;

  assign pc_inc = pc + PC_W'(1);

`ifdef HW_LOOP_EN
  logic [PC_W-1:0] loop_start;
  logic [PC_W-1:0] loop_end;
  logic            at_end;

  assign at_end    = loop_active && (pc == loop_end);
  assign loop_back = at_end && (loop_remaining != '0);

  // loop_set takes precedence over a coincident back-branch count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loop_start     <= '0;
      loop_end       <= '0;
      loop_remaining <= '0;
      loop_active    <= 1'b0;
    end else if (!hold) begin
      if (loop_set) begin
        loop_start     <= pc_inc;
        loop_end       <= loop_end_addr;
        loop_remaining <= loop_count_in;
        loop_active    <= 1'b1;
      end else if (src == SRC_LOOP) begin
        loop_remaining <= loop_remaining - LOOP_W'(1);
      end else if (at_end && src == SRC_INC) begin
        loop_active <= 1'b0;
      end
    end
  end
`else
  logic unused_loop;
  assign unused_loop    = ^{loop_set, loop_count_in, loop_end_addr};
  assign loop_back      = 1'b0;
  assign loop_active    = 1'b0;
  assign loop_remaining = '0;
`endif

  always_comb begin
    if (hold)                   src = SRC_HOLD;
    else if (ret)               src = SRC_RET;
    else if (call)              src = SRC_CALL;
    else if (jmp)               src = SRC_JMP;
    else if (jmp_nz && !dont_jmp) src = SRC_JNZ;
    else if (loop_back)         src = SRC_LOOP;
    else                        src = SRC_INC;
  end

  always_comb begin
    nxt    = pc_inc;
    push   = 1'b0;
    pop    = 1'b0;
    set_of = 1'b0;
    set_uf = 1'b0;
    unique case (src)
      SRC_HOLD: nxt = pc;
      SRC_RET: begin
        if (empty) set_uf = 1'b1;
        else begin
          nxt = top;
          pop = 1'b1;
        end
      end
      SRC_CALL: begin
        if (full) set_of = 1'b1;
        else begin
          nxt  = jmp_addr;
          push = 1'b1;
        end
      end
      SRC_JMP:  nxt = jmp_addr;
      SRC_JNZ:  nxt = jmp_addr;
`ifdef HW_LOOP_EN
      SRC_LOOP: nxt = loop_start;
`else
      SRC_LOOP: nxt = pc_inc;
`endif
      SRC_INC:  nxt = pc_inc;
      default:  nxt = pc_inc;
    endcase
  end

  assign pm_addr = reset ? nxt : RESET_VEC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc              <= RESET_VEC;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      pc <= pm_addr;
      if (set_of) stack_overflow  <= 1'b1;
      if (set_uf) stack_underflow <= 1'b1;
    end
  end

  seq_return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (top),
    .sp        (sp),
    .full      (full),
    .empty     (empty)
  );

endmodule
